// File: rtl/hazard_pkg.sv
// ============================================================================
// Module      : hazard_pkg
// Description : Shared types and constants for the pipeline hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_pkg;

    localparam int REG_ADDR_W = 3;
    localparam int TMR_W      = 8;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LSTALL = 2'd1,
        FLUSH  = 2'd2,
        MWAIT  = 2'd3
    } hz_state_e;

    // A bubble is an all-zero instruction word: no register write, no memory access.
    localparam logic [15:0]           NOP_INSTR    = 16'h0000;
    localparam logic [REG_ADDR_W-1:0] NOP_RD       = '0;
    localparam logic                  NOP_REGWRITE = 1'b0;
    localparam logic                  NOP_MEMREQ   = 1'b0;

endpackage

`default_nettype wire

// File: rtl/sat_counter16.sv
// ============================================================================
// Module      : sat_counter16
// Description : 16-bit counter with enable and clear; holds at all-ones.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter16 (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic        clr_i,
    output logic [15:0] cnt_o
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Stall / bubble / flush sequencer for the 3-stage pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int FLUSH_CYCLES      = 1,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int MEM_TIMEOUT       = 15
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [REG_ADDR_W-1:0] id_rs_addr_i,
    input  logic                  id_rs_read_i,
    input  logic [REG_ADDR_W-1:0] em_write_addr_i,
    input  logic                  em_memread_i,
    input  logic                  em_regwrite_i,
    input  logic                  em_branch_taken_i,
    input  logic                  em_mem_req_i,
    input  logic                  mem_ready_i,
    input  logic                  stat_clr_i,
    output logic                  pc_en_o,
    output logic                  ifid_en_o,
    output logic                  ifid_flush_o,
    output logic                  idem_bubble_o,
    output logic                  emwb_en_o,
    output logic                  mem_timeout_o,
    output logic [1:0]            state_o,
    output logic [15:0]           stall_cnt_o
);

    localparam logic [TMR_W-1:0] FLUSH_INIT = TMR_W'(FLUSH_CYCLES - 1);
    localparam logic [TMR_W-1:0] LOAD_INIT  = TMR_W'(LOAD_STALL_CYCLES - 1);
    localparam logic [TMR_W-1:0] TO_LAST    = TMR_W'(MEM_TIMEOUT - 1);
    localparam logic             TO_IMM     = (MEM_TIMEOUT == 1);

    hz_state_e        state_q, state_d;
    logic [TMR_W-1:0] cnt_q, cnt_d;
    logic             w_mem_wait;
    logic             w_load_haz;
    logic [15:0]      w_stall_cnt;

    assign w_mem_wait = em_mem_req_i & ~mem_ready_i;
    assign w_load_haz = id_rs_read_i & em_memread_i & em_regwrite_i &
                        (em_write_addr_i == id_rs_addr_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The RUN/LSTALL cycle that detects a memory wait is itself wait cycle 1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (w_mem_wait) begin
                    if (!TO_IMM) begin
                        state_d = MWAIT;
                        cnt_d   = TMR_W'(1);
                    end
                end else if (em_branch_taken_i) begin
                    if (FLUSH_CYCLES > 1) begin
                        state_d = FLUSH;
                        cnt_d   = FLUSH_INIT;
                    end
                end else if (w_load_haz) begin
                    if (LOAD_STALL_CYCLES > 1) begin
                        state_d = LSTALL;
                        cnt_d   = LOAD_INIT;
                    end
                end
            end
            LSTALL: begin
                if (w_mem_wait) begin
                    state_d = TO_IMM ? RUN : MWAIT;
                    cnt_d   = TO_IMM ? '0 : TMR_W'(1);
                end else begin
                    cnt_d = cnt_q - TMR_W'(1);
                    if (cnt_q == TMR_W'(1)) state_d = RUN;
                end
            end
            FLUSH: begin
                cnt_d = cnt_q - TMR_W'(1);
                if (cnt_q == TMR_W'(1)) state_d = RUN;
            end
            MWAIT: begin
                if (mem_ready_i || (cnt_q == TO_LAST)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + TMR_W'(1);
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        pc_en_o       = 1'b1;
        ifid_en_o     = 1'b1;
        emwb_en_o     = 1'b1;
        ifid_flush_o  = 1'b0;
        idem_bubble_o = 1'b0;
        mem_timeout_o = 1'b0;
        if (!rst_i) begin
            case (state_q)
                RUN, LSTALL: begin
                    if (w_mem_wait) begin
                        if (TO_IMM) begin
                            mem_timeout_o = 1'b1;
                        end else begin
                            pc_en_o   = 1'b0;
                            ifid_en_o = 1'b0;
                            emwb_en_o = 1'b0;
                        end
                    end else if ((state_q == RUN) && em_branch_taken_i) begin
                        ifid_flush_o  = 1'b1;
                        idem_bubble_o = 1'b1;
                    end else if ((state_q == LSTALL) || w_load_haz) begin
                        pc_en_o       = 1'b0;
                        ifid_en_o     = 1'b0;
                        idem_bubble_o = 1'b1;
                    end
                end
                FLUSH: begin
                    ifid_flush_o  = 1'b1;
                    idem_bubble_o = 1'b1;
                end
                MWAIT: begin
                    if (!mem_ready_i) begin
                        if (cnt_q == TO_LAST) begin
                            mem_timeout_o = 1'b1;
                        end else begin
                            pc_en_o   = 1'b0;
                            ifid_en_o = 1'b0;
                            emwb_en_o = 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    sat_counter16 u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (~pc_en_o),
        .clr_i (stat_clr_i),
        .cnt_o (w_stall_cnt)
    );

    assign state_o     = rst_i ? RUN : state_q;
    assign stall_cnt_o = rst_i ? 16'h0000 : w_stall_cnt;

endmodule

`default_nettype wire
